cordic_pipe: RTL and testbench



---
 rtl/cordic_pipe_if.sv | 17 +
 rtl/cordic_pipe.sv | 140 ++++++++++++++
 tb/tb_cordic_pipe.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_pipe_if.sv
// cordic_pipe_if: sample-in / result-out handshake bundle for cordic_pipe
interface cordic_pipe_if #(
  parameter int WIDTH = 20,
  parameter int TAG_W = 4
);
  logic signed [WIDTH-1:0] x_i, y_i, z_i, x_o, y_o, z_o;
  logic                    mode_i, vld_i, rdy_o, mode_o, vld_o, rdy_i;
  logic [TAG_W-1:0]        tag_i, tag_o;
  modport slave (
    input  x_i, y_i, z_i, mode_i, tag_i, vld_i, rdy_i,
    output rdy_o, x_o, y_o, z_o, mode_o, tag_o, vld_o
  );
  modport master (
    output x_i, y_i, z_i, mode_i, tag_i, vld_i, rdy_i,
    input  rdy_o, x_o, y_o, z_o, mode_o, tag_o, vld_o
  );
endinterface

// File: rtl/cordic_pipe.sv
// cordic_pipe: stallable pipelined CORDIC, per-sample rotation/vectoring with optional gain compensation
module cordic_pipe #(
  parameter int WIDTH     = 20,
  parameter int FRAC      = 15,
  parameter int N_STEPS   = 16,
  parameter int GAIN_COMP = 1,
  parameter int TAG_W     = 4
) (
  input logic         clk,
  input logic         rst,
  cordic_pipe_if.slave io
);
  typedef logic signed [WIDTH-1:0] word_t;
  typedef logic [N_STEPS-1:0][WIDTH-1:0] atan_t;
  localparam longint ONE = 1;
  // atan(1/n) scaled by 2^62 via its Taylor series
  function automatic longint atan_inv(longint n);
    longint p = (ONE <<< 62) / n;
    longint s = 0;
    for (int k = 0; k < 40; k++) begin
      s = s + ((k % 2) != 0 ? -p : p) / (2 * k + 1);
      p = p / (n * n);
    end
    return s;
  endfunction
  function automatic atan_t atan_tab();
    atan_t t;
    longint a;
    for (int i = 0; i < N_STEPS; i++) begin
      a = i == 0 ? 4 * atan_inv(5) - atan_inv(239) : atan_inv(ONE <<< i);
      t[i] = WIDTH'((a + (ONE <<< (61 - FRAC))) >>> (62 - FRAC));
    end
    return t;
  endfunction
  // K^2 accumulated as repeated x*4^i/(4^i+1), then an integer square root
  function automatic longint gain_k();
    longint k2 = ONE <<< 62;
    longint s = 0;
    longint t;
    for (int i = 0; i < N_STEPS; i++) k2 = k2 - k2 / ((ONE <<< (2 * i)) + 1);
    for (int b = 31; b >= 0; b--) begin
      t = s | (ONE <<< b);
      if (t * t <= k2) s = t;
    end
    return (s + (ONE <<< (30 - FRAC))) >>> (31 - FRAC);
  endfunction
  localparam atan_t ATAN = atan_tab();
  word_t x_s [N_STEPS], y_s [N_STEPS], z_s [N_STEPS];
  word_t x_n [N_STEPS], y_n [N_STEPS], z_n [N_STEPS];
  word_t x_r [N_STEPS], y_r [N_STEPS], z_r [N_STEPS];
  logic [TAG_W-1:0] t_s [N_STEPS], t_r [N_STEPS];
  logic [N_STEPS-1:0] m_s, v_s, m_r, v_r, d;
  word_t xf, yf, zf;
  logic mf, vf, en;
  logic [TAG_W-1:0] tf;
  assign en = !vf || io.rdy_i;
  assign io.rdy_o = en;
  assign io.x_o = xf;
  assign io.y_o = yf;
  assign io.z_o = zf;
  assign io.mode_o = mf;
  assign io.tag_o = tf;
  assign io.vld_o = vf;
  // d = 1 means +1
  always_comb begin
    x_s[0] = io.x_i;
    y_s[0] = io.y_i;
    z_s[0] = io.z_i;
    t_s[0] = io.tag_i;
    m_s[0] = io.mode_i;
    v_s[0] = io.vld_i;
    for (int i = 1; i < N_STEPS; i++) begin
      x_s[i] = x_r[i-1];
      y_s[i] = y_r[i-1];
      z_s[i] = z_r[i-1];
      t_s[i] = t_r[i-1];
      m_s[i] = m_r[i-1];
      v_s[i] = v_r[i-1];
    end
    for (int i = 0; i < N_STEPS; i++) begin
      d[i] = m_s[i] ? y_s[i][WIDTH-1] : !z_s[i][WIDTH-1];
      x_n[i] = d[i] ? x_s[i] - (y_s[i] >>> i) : x_s[i] + (y_s[i] >>> i);
      y_n[i] = d[i] ? y_s[i] + (x_s[i] >>> i) : y_s[i] - (x_s[i] >>> i);
      z_n[i] = d[i] ? z_s[i] - ATAN[i] : z_s[i] + ATAN[i];
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      v_r <= '0;
      m_r <= '0;
      for (int i = 0; i < N_STEPS; i++) begin
        x_r[i] <= '0;
        y_r[i] <= '0;
        z_r[i] <= '0;
        t_r[i] <= '0;
      end
    end else if (en) begin
      v_r <= v_s;
      m_r <= m_s;
      for (int i = 0; i < N_STEPS; i++) begin
        x_r[i] <= x_n[i];
        y_r[i] <= y_n[i];
        z_r[i] <= z_n[i];
        t_r[i] <= t_s[i];
      end
    end
  if (GAIN_COMP != 0) begin : g_gain
    localparam logic signed [2*WIDTH-1:0] KG = (2*WIDTH)'(gain_k());
    localparam logic signed [2*WIDTH-1:0] HALF = (2*WIDTH)'(ONE <<< (FRAC - 1));
    logic signed [2*WIDTH-1:0] px, py;
    word_t za;
    logic ma, va;
    logic [TAG_W-1:0] ta;
    always_ff @(posedge clk)
      if (!rst) begin
        {px, py, za, ma, va, ta} <= '0;
        {xf, yf, zf, mf, vf, tf} <= '0;
      end else if (en) begin
        px <= (2*WIDTH)'(x_r[N_STEPS-1]) * KG;
        py <= (2*WIDTH)'(y_r[N_STEPS-1]) * KG;
        za <= z_r[N_STEPS-1];
        ma <= m_r[N_STEPS-1];
        va <= v_r[N_STEPS-1];
        ta <= t_r[N_STEPS-1];
        xf <= word_t'((px + HALF) >>> FRAC);
        yf <= word_t'((py + HALF) >>> FRAC);
        zf <= za;
        mf <= ma;
        vf <= va;
        tf <= ta;
      end
  end else begin : g_bypass
    assign xf = x_r[N_STEPS-1];
    assign yf = y_r[N_STEPS-1];
    assign zf = z_r[N_STEPS-1];
    assign mf = m_r[N_STEPS-1];
    assign vf = v_r[N_STEPS-1];
    assign tf = t_r[N_STEPS-1];
  end
endmodule

// File: tb/tb_cordic_pipe.sv
// tb_cordic_pipe: directed vectors, bit-accurate scoreboard streams, backpressure and reset flushes
module tb_cordic_pipe;
  localparam int L = 18;
  typedef logic signed [19:0] w_t;
  typedef struct { int x, y, z, mode, tag, ex, ey, ez, tol; } vec_t;
  typedef struct { w_t x, y, z; logic mode; logic [3:0] tag; } smp_t;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  cordic_pipe_if #(.WIDTH(20), .TAG_W(4)) a ();
  cordic_pipe_if #(.WIDTH(16), .TAG_W(4)) b ();
  cordic_pipe dut (.clk(clk), .rst(rst), .io(a));
  cordic_pipe #(.WIDTH(16), .FRAC(12), .N_STEPS(12), .GAIN_COMP(0), .TAG_W(4)) dut_s (.clk(clk), .rst(rst), .io(b));
  int checks = 0, errors = 0;
  int atn [16];
  longint kk;
  real kr;
  smp_t exp_q [$];
  smp_t held;
  logic mon_en = 0, hold_pend = 0, bp_on = 0;
  int got = 0, first_cyc = 0, last_cyc = 0, cyc = 0;
  vec_t vecs [7];
  task automatic chk(input string nm, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask
  function automatic smp_t model(input smp_t s);
    w_t x = s.x, y = s.y, z = s.z, xn;
    int sd;
    longint p;
    smp_t r;
    for (int i = 0; i < 16; i++) begin
      sd = s.mode ? (y < 0 ? 1 : -1) : (z >= 0 ? 1 : -1);
      xn = 20'(x - sd * (y >>> i));
      y = 20'(y + sd * (x >>> i));
      x = xn;
      z = 20'(z - sd * atn[i]);
    end
    p = longint'(x) * kk;
    r.x = 20'((p + 16384) >>> 15);
    p = longint'(y) * kk;
    r.y = 20'((p + 16384) >>> 15);
    r.z = z;
    r.mode = s.mode;
    r.tag = s.tag;
    return r;
  endfunction
  function automatic smp_t rnd(input logic md, input int k);
    smp_t s;
    s.mode = md;
    s.tag = 4'(k);
    s.x = md ? 20'($urandom_range(0, 200000)) : 20'(int'($urandom_range(0, 400000)) - 200000);
    s.y = 20'(int'($urandom_range(0, 400000)) - 200000);
    s.z = md ? 20'(int'($urandom_range(0, 20000)) - 10000) : 20'(int'($urandom_range(0, 102942)) - 51471);
    return s;
  endfunction
  task automatic drive(input smp_t s);
    a.x_i = s.x;
    a.y_i = s.y;
    a.z_i = s.z;
    a.mode_i = s.mode;
    a.tag_i = s.tag;
    a.vld_i = 1;
  endtask
  task automatic send(input smp_t s);
    logic ok = 0;
    drive(s);
    exp_q.push_back(model(s));
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = a.rdy_o;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      $display("FAIL send_timeout got rdy_o 0 want 1");
      $fatal(1);
    end
  endtask
  // assumes an idle pipeline; latency counts the accepting edge as 1
  task automatic run_one(input smp_t s, output smp_t o, output int lat);
    drive(s);
    @(posedge clk);
    #1;
    a.vld_i = 0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (a.vld_o || lat >= 100) break;
      lat++;
    end
    o.x = a.x_o;
    o.y = a.y_o;
    o.z = a.z_o;
    o.mode = a.mode_o;
    o.tag = a.tag_o;
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) if (bp_on) begin
    #1;
    a.rdy_i = 1'($urandom_range(0, 1));
  end
  always @(negedge clk) begin
    smp_t e;
    cyc++;
    if (mon_en) begin
      if (hold_pend) begin
        chk("hold_vld", longint'(a.vld_o), 1, 1);
        chk("hold_x", longint'(a.x_o), longint'(held.x), longint'(held.x));
        chk("hold_z", longint'(a.z_o), longint'(held.z), longint'(held.z));
        chk("hold_tag", longint'(a.tag_o), longint'(held.tag), longint'(held.tag));
      end
      hold_pend = a.vld_o && !a.rdy_i;
      held.x = a.x_o;
      held.z = a.z_o;
      held.tag = a.tag_o;
      if (a.vld_o && a.rdy_i) begin
        if (exp_q.size() == 0) chk("extra_output", 1, 0, 0);
        else begin
          e = exp_q.pop_front();
          chk("sb_x", longint'(a.x_o), longint'(e.x), longint'(e.x));
          chk("sb_y", longint'(a.y_o), longint'(e.y), longint'(e.y));
          chk("sb_z", longint'(a.z_o), longint'(e.z), longint'(e.z));
          chk("sb_mode", longint'(a.mode_o), longint'(e.mode), longint'(e.mode));
          chk("sb_tag", longint'(a.tag_o), longint'(e.tag), longint'(e.tag));
          got++;
          if (got == 1) first_cyc = cyc;
          last_cyc = cyc;
        end
      end
    end
  end
  initial begin
    smp_t s, o, m;
    int lat, seen;
    vecs = '{
      '{32768, 0, 25736, 0, 1, 23170, 23170, 0, 4},
      '{32768, 32768, 0, 1, 2, 46341, 0, 25736, 4},
      '{32768, 0, -25736, 0, 3, 23170, -23170, 0, 4},
      '{16384, 0, 51471, 0, 4, 0, 16384, 0, 6},
      '{30000, -30000, 0, 1, 5, 42426, 0, -25736, 6},
      '{0, 10000, 0, 0, 6, 0, 10000, 0, 6},
      '{20000, 0, 0, 1, 7, 20000, 0, 0, 6}
    };
    a.x_i = 0; a.y_i = 0; a.z_i = 0; a.mode_i = 0; a.tag_i = 0; a.vld_i = 0; a.rdy_i = 1;
    b.x_i = 0; b.y_i = 0; b.z_i = 0; b.mode_i = 0; b.tag_i = 0; b.vld_i = 0; b.rdy_i = 1;
    kr = 1.0;
    for (int i = 0; i < 16; i++) begin
      atn[i] = $rtoi($atan(2.0 ** (-i)) * 32768.0 + 0.5);
      kr = kr / $sqrt(1.0 + 2.0 ** (-2 * i));
    end
    kk = longint'($rtoi(kr * 32768.0 + 0.5));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", longint'(a.vld_o), 0, 0);
    chk("rst_x", longint'(a.x_o), 0, 0);
    chk("rst_y", longint'(a.y_o), 0, 0);
    chk("rst_z", longint'(a.z_o), 0, 0);
    chk("rst_mode", longint'(a.mode_o), 0, 0);
    chk("rst_tag", longint'(a.tag_o), 0, 0);
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("rst_rdy", longint'(a.rdy_o), 1, 1);
    @(posedge clk);
    #1;
    foreach (vecs[k]) begin
      s.x = 20'(vecs[k].x);
      s.y = 20'(vecs[k].y);
      s.z = 20'(vecs[k].z);
      s.mode = vecs[k].mode[0];
      s.tag = 4'(vecs[k].tag);
      run_one(s, o, lat);
      m = model(s);
      chk("vec_latency", longint'(lat), L, L);
      chk("vec_x", longint'(o.x), vecs[k].ex - vecs[k].tol, vecs[k].ex + vecs[k].tol);
      chk("vec_y", longint'(o.y), vecs[k].ey - vecs[k].tol, vecs[k].ey + vecs[k].tol);
      chk("vec_z", longint'(o.z), vecs[k].ez - vecs[k].tol, vecs[k].ez + vecs[k].tol);
      chk("vec_mode", longint'(o.mode), vecs[k].mode, vecs[k].mode);
      chk("vec_tag", longint'(o.tag), vecs[k].tag, vecs[k].tag);
      chk("vec_model_x", longint'(o.x), longint'(m.x), longint'(m.x));
      chk("vec_model_y", longint'(o.y), longint'(m.y), longint'(m.y));
      chk("vec_model_z", longint'(o.z), longint'(m.z), longint'(m.z));
    end
    // back-to-back alternating modes
    got = 0;
    hold_pend = 0;
    mon_en = 1;
    for (int k = 0; k < 64; k++) send(rnd(k[0], k));
    a.vld_i = 0;
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    chk("stream_count", longint'(got), 64, 64);
    chk("stream_gapless", longint'(last_cyc - first_cyc), 63, 63);
    @(posedge clk);
    #1;
    // random backpressure
    got = 0;
    bp_on = 1;
    for (int k = 0; k < 30; k++) send(rnd(1'($urandom_range(0, 1)), k));
    a.vld_i = 0;
    bp_on = 0;
    @(posedge clk);
    #2;
    a.rdy_i = 1;
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    chk("bp_count", longint'(got), 30, 30);
    chk("bp_left", longint'(exp_q.size()), 0, 0);
    mon_en = 0;
    @(posedge clk);
    #1;
    // reset with 10 samples in flight
    for (int k = 0; k < 10; k++) send(rnd(k[0], k));
    exp_q.delete();
    a.vld_i = 0;
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("flush_vld", longint'(a.vld_o), 0, 0);
    chk("flush_rdy", longint'(a.rdy_o), 1, 1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (a.vld_o) seen++;
    end
    chk("flush_stale", longint'(seen), 0, 0);
    @(posedge clk);
    #1;
    s = rnd(0, 9);
    run_one(s, o, lat);
    m = model(s);
    chk("post_rst_latency", longint'(lat), L, L);
    chk("post_rst_x", longint'(o.x), longint'(m.x), longint'(m.x));
    // reset overrides a stalled, full output
    a.rdy_i = 0;
    drive(rnd(1, 3));
    @(posedge clk);
    #1;
    a.vld_i = 0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("stall_vld", longint'(a.vld_o), 1, 1);
    chk("stall_rdy", longint'(a.rdy_o), 0, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    a.rdy_i = 1;
    @(negedge clk);
    chk("stall_flush_vld", longint'(a.vld_o), 0, 0);
    @(posedge clk);
    #1;
    // uncompensated 16-bit, 12-stage instance
    b.x_i = 16'sd2048;
    b.tag_i = 4'd9;
    b.vld_i = 1;
    @(posedge clk);
    #1;
    b.vld_i = 0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (b.vld_o || lat >= 100) break;
      lat++;
    end
    chk("nogain_latency", longint'(lat), 12, 12);
    chk("nogain_x", longint'(b.x_o), 3370, 3376);
    chk("nogain_tag", longint'(b.tag_o), 9, 9);
    chk("nogain_mode", longint'(b.mode_o), 0, 0);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
